hb_dec_tdm: RTL and testbench

//  Multichannel halfband decimate-by-2 filter, last stage of the DDC chain.
//  NCH channels share one input strobe; taps are programmable. Impulse response
//  [h0 0 h1 0 .. h(N-1) 0.5 h(N-1) .. 0 h0], length 4*NCOEF-1.
//  One pre-add/multiply/accumulate (MAC) datapath is time-shared over all channels and coefficients.

---
 rtl/hb_dec_tdm.sv | 210 +++++++++++++++++++++
 tb/tb_hb_dec_tdm.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_dec_tdm.sv
// hb_dec_tdm: multichannel halfband decimate-by-2 filter. One pre-add/MAC
// datapath is time-shared over every channel and symmetric coefficient pair.
module hb_dec_tdm #(
    parameter int WIDTH  = 24,
    parameter int CWIDTH = 18,
    parameter int NCOEF  = 8,
    parameter int NCH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     bypass,
    input  logic                     stb_in,
    input  logic [NCH*WIDTH-1:0]     data_in,
    input  logic                     coef_wr,
    input  logic [$clog2(NCOEF)-1:0] coef_addr,
    input  logic [CWIDTH-1:0]        coef_data,
    output logic                     stb_out,
    output logic [NCH*WIDTH-1:0]     data_out,
    output logic                     overrun
);
    localparam int AW   = $clog2(NCOEF);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int L    = 4 * NCOEF - 1;
    localparam int PW   = WIDTH + 1 + CWIDTH;
    localparam int ACCW = WIDTH + CWIDTH + AW + 1;
    localparam int SW   = ACCW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [SW-1:0] RND  = SW'(1) <<< (CWIDTH - 2);
    localparam logic signed [SW-1:0] MAXV =
        {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV =
        {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [1:0]               state_q, state_d;
    logic                     phase_q, phase_d;
    logic [CHW-1:0]           ch_q, ch_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic signed [CWIDTH-1:0] coef_q [NCOEF];
    logic signed [CWIDTH-1:0] coef_d [NCOEF];
    logic signed [WIDTH-1:0]  dl_q [NCH][L];
    logic signed [ACCW-1:0]   acc_q [NCH];
    logic signed [ACCW-1:0]   acc_d [NCH];
    logic signed [WIDTH-1:0]  y_q [NCH];
    logic signed [WIDTH-1:0]  y_c [NCH];
    logic signed [SW-1:0]     sum_c [NCH];
    logic signed [SW-1:0]     shr_c [NCH];
    logic                     stb_q, stb_d;
    logic [NCH*WIDTH-1:0]     dout_q, dout_d;
    logic                     ovr_q, ovr_d;

    logic                     active, accept;
    logic signed [WIDTH-1:0]  tap_a, tap_b;
    logic signed [CWIDTH-1:0] h_sel;
    logic signed [WIDTH:0]    pre;
    logic signed [PW-1:0]     prod;

    assign active = run && !bypass && stb_in;
    assign accept = active && (state_q == S_IDLE);

    // Outer tap x[n-2i] pairs with its mirror x[n-(4N-2)+2i]
    always_comb begin
        tap_a = '0;
        tap_b = '0;
        h_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < NCOEF; i++) begin
                if (ch_q == CHW'(c) && idx_q == AW'(i)) begin
                    tap_a = dl_q[c][2*i];
                    tap_b = dl_q[c][L-1-2*i];
                    h_sel = coef_q[i];
                end
            end
        end
    end

    assign pre  = {tap_a[WIDTH-1], tap_a} + {tap_b[WIDTH-1], tap_b};
    assign prod = pre * h_sel;

    // Centre tap is 0.5, so it folds in as a shift; round half up, saturate
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            sum_c[c] = SW'(acc_q[c])
                     + (SW'(dl_q[c][2*NCOEF-1]) <<< (CWIDTH - 2))
                     + RND;
            shr_c[c] = sum_c[c] >>> (CWIDTH - 1);
            if (shr_c[c] > MAXV)
                y_c[c] = MAXV[WIDTH-1:0];
            else if (shr_c[c] < MINV)
                y_c[c] = MINV[WIDTH-1:0];
            else
                y_c[c] = shr_c[c][WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ch_d    = ch_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        coef_d  = coef_q;
        stb_d   = 1'b0;
        dout_d  = dout_q;
        ovr_d   = ovr_q;
        if (!run) begin
            ovr_d = 1'b0;
            for (int i = 0; i < NCOEF; i++)
                if (coef_wr && coef_addr == AW'(i))
                    coef_d[i] = coef_data;
        end else if (active && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end
        if (bypass) begin
            state_d = S_IDLE;
            phase_d = 1'b0;
            if (stb_in) begin
                stb_d  = 1'b1;
                dout_d = data_in;
            end
        end else if (!run) begin
            state_d = S_IDLE;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        phase_d = !phase_q;
                        if (phase_q) begin
                            state_d = S_MAC;
                            ch_d    = '0;
                            idx_d   = '0;
                        end
                    end
                end
                S_MAC: begin
                    for (int c = 0; c < NCH; c++)
                        if (ch_q == CHW'(c))
                            acc_d[c] = ((idx_q == '0) ? '0 : acc_q[c])
                                     + ACCW'(prod);
                    if (idx_q == AW'(NCOEF - 1)) begin
                        idx_d = '0;
                        if (ch_q == CHW'(NCH - 1))
                            state_d = S_FINAL;
                        else
                            ch_d = ch_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_FINAL: state_d = S_OUT;
                S_OUT: begin
                    state_d = S_IDLE;
                    stb_d   = 1'b1;
                    for (int c = 0; c < NCH; c++)
                        dout_d[c*WIDTH +: WIDTH] = y_q[c];
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Delay lines are deliberately left out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            ch_q    <= '0;
            idx_q   <= '0;
            stb_q   <= 1'b0;
            dout_q  <= '0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < NCOEF; i++)
                coef_q[i] <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
                y_q[c]   <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ch_q    <= ch_d;
            idx_q   <= idx_d;
            stb_q   <= stb_d;
            dout_q  <= dout_d;
            ovr_q   <= ovr_d;
            coef_q  <= coef_d;
            acc_q   <= acc_d;
            if (state_q == S_FINAL)
                y_q <= y_c;
            if (accept) begin
                for (int c = 0; c < NCH; c++) begin
                    dl_q[c][0] <= data_in[c*WIDTH +: WIDTH];
                    for (int k = 1; k < L; k++)
                        dl_q[c][k] <= dl_q[c][k-1];
                end
            end
        end
    end

    assign stb_out  = stb_q;
    assign data_out = dout_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_hb_dec_tdm.sv
// tb_hb_dec_tdm: samples are checked against a direct convolution with the
// expanded halfband impulse response, plus directed impulse/limit cases.
module tb_hb_dec_tdm;
    localparam int W   = 16;
    localparam int CW  = 18;
    localparam int N   = 2;
    localparam int NCH = 2;
    localparam int L   = 4 * N - 1;
    localparam int LAT = NCH * N + 3;
    localparam int AW  = $clog2(N);

    typedef struct {
        int c;
        bit dc;
        int d0;
        int d1;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             bypass = 1'b0;
    logic             stb_in = 1'b0;
    logic [NCH*W-1:0] data_in = '0;
    logic             coef_wr = 1'b0;
    logic [AW-1:0]    coef_addr = '0;
    logic [CW-1:0]    coef_data = '0;
    logic             stb_out;
    logic [NCH*W-1:0] data_out;
    logic             overrun;

    hb_dec_tdm #(.WIDTH(W), .CWIDTH(CW), .NCOEF(N), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .run(run), .bypass(bypass),
        .stb_in(stb_in), .data_in(data_in), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .stb_out(stb_out), .data_out(data_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   failures = 0;
    ent_t expq[$];
    int   hist0[$];
    int   hist1[$];
    int   mc[N];
    bit   mph;
    int   mbusy;
    bit   movr;
    int   mo0, mo1;
    int   obs0[$];
    int   obs1[$];
    int   obsc[$];
    int   t1[5] = '{128, -1024, -1024, 128, 0};
    int   t2[3] = '{0, 8192, 0};

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic longint hfull(input int k);
        if (k == 2 * N - 1) return longint'(1) << (CW - 2);
        if (k % 2 != 0) return 0;
        if (k < 2 * N - 1) return longint'(mc[k/2]);
        return longint'(mc[(L-1-k)/2]);
    endfunction

    function automatic int yref(input int ch, output bit dc);
        longint s;
        int     v;
        int     sz;
        s  = 0;
        dc = 1'b0;
        sz = (ch == 0) ? hist0.size() : hist1.size();
        for (int k = 0; k < L; k++) begin
            if (hfull(k) == 0) continue;
            if (k >= sz) begin
                dc = 1'b1;
                continue;
            end
            v = (ch == 0) ? hist0[k] : hist1[k];
            s += hfull(k) * longint'(v);
        end
        s = (s + (longint'(1) << (CW - 2))) >>> (CW - 1);
        if (s > longint'(2**(W-1) - 1)) s = 2**(W-1) - 1;
        if (s < -longint'(2**(W-1))) s = -longint'(2**(W-1));
        return int'(s);
    endfunction

    task automatic mreset();
        mph   = 1'b0;
        mbusy = 0;
        movr  = 1'b0;
        mo0   = 0;
        mo1   = 0;
        expq.delete();
        for (int i = 0; i < N; i++) mc[i] = 0;
    endtask

    task automatic flush(input int e);
        ent_t keep[$];
        foreach (expq[i]) if (expq[i].c < e) keep.push_back(expq[i]);
        expq = keep;
    endtask

    task automatic mupd();
        int   e;
        ent_t t;
        bit   dc0, dc1;
        e = cyc + 1;
        if (rst) begin
            mreset();
            return;
        end
        if (bypass) begin
            mph   = 1'b0;
            mbusy = 0;
            flush(e);
            if (stb_in) begin
                t.c  = e;
                t.dc = 1'b0;
                t.d0 = sx(data_in[W-1:0]);
                t.d1 = sx(data_in[2*W-1:W]);
                expq.push_back(t);
            end
        end else if (!run) begin
            mph   = 1'b0;
            mbusy = 0;
            flush(e);
        end else if (stb_in) begin
            if (e >= mbusy) begin
                hist0.push_front(sx(data_in[W-1:0]));
                hist1.push_front(sx(data_in[2*W-1:W]));
                if (hist0.size() > L) void'(hist0.pop_back());
                if (hist1.size() > L) void'(hist1.pop_back());
                if (mph) begin
                    t.c  = e + LAT - 1;
                    t.d0 = yref(0, dc0);
                    t.d1 = yref(1, dc1);
                    t.dc = dc0 | dc1;
                    expq.push_back(t);
                    mbusy = e + LAT;
                end
                mph = !mph;
            end else begin
                movr = 1'b1;
            end
        end
        if (!run) movr = 1'b0;
        if (!run && coef_wr) mc[coef_addr] = int'($signed(coef_data));
    endtask

    task automatic mon();
        bit es;
        es = 1'b0;
        while (expq.size() > 0 && expq[0].c < cyc) begin
            chk("stb_missing", 0, 1);
            void'(expq.pop_front());
        end
        if (expq.size() > 0 && expq[0].c == cyc) begin
            es  = 1'b1;
            mo0 = expq[0].dc ? sx(data_out[W-1:0]) : expq[0].d0;
            mo1 = expq[0].dc ? sx(data_out[2*W-1:W]) : expq[0].d1;
            void'(expq.pop_front());
        end
        chk("stb_out", longint'(stb_out), longint'(es));
        if (stb_out === 1'b1) begin
            obs0.push_back(sx(data_out[W-1:0]));
            obs1.push_back(sx(data_out[2*W-1:W]));
            obsc.push_back(cyc);
        end
        chk("data_out0", sx(data_out[W-1:0]), mo0);
        chk("data_out1", sx(data_out[2*W-1:W]), mo1);
        chk("overrun", longint'(overrun), longint'(movr));
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        mupd();
        @(posedge clk);
        #1;
        stb_in  = 1'b0;
        coef_wr = 1'b0;
    endtask

    task automatic send(input int d0, input int d1, input int gap);
        stb_in  = 1'b1;
        data_in = {W'(d1), W'(d0)};
        repeat (gap) step();
    endtask

    task automatic wcoef(input int a, input int v);
        coef_wr   = 1'b1;
        coef_addr = AW'(a);
        coef_data = CW'(v);
        step();
    endtask

    task automatic load(input int h0, input int h1);
        run = 1'b0;
        wcoef(0, h0);
        wcoef(1, h1);
        run = 1'b1;
        step();
    endtask

    function automatic int rsamp();
        case ($urandom_range(0, 7))
            0: return 32767;
            1: return -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    function automatic int rcoef();
        return int'($urandom_range(0, 2**CW - 1)) - 2**(CW-1);
    endfunction

    initial begin
        int e0;
        int n;
        mreset();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();
        run = 1'b1;
        step();
        repeat (8) send(0, 0, LAT);

        load(1024, -8192);
        obs0.delete();
        obs1.delete();
        for (int i = 0; i < 10; i++) send(i == 1 ? 16384 : 0, 0, LAT);
        repeat (LAT) step();
        chk("t1_count", obs0.size(), 5);
        for (int i = 0; i < 5 && i < obs0.size(); i++) begin
            chk("t1_ch0", obs0[i], t1[i]);
            chk("t1_ch1", obs1[i], 0);
        end

        obs0.delete();
        obs1.delete();
        for (int i = 0; i < 6; i++) send(0, i == 0 ? 16384 : 0, LAT);
        repeat (LAT) step();
        chk("t2_count", obs1.size(), 3);
        for (int i = 0; i < 3 && i < obs1.size(); i++) begin
            chk("t2_ch1", obs1[i], t2[i]);
            chk("t2_ch0", obs0[i], 0);
        end

        send(5, 6, LAT);
        e0 = cyc + 1;
        send(7, 8, LAT);
        repeat (2) step();
        chk("t3_latency", obsc[$] - e0 + 1, LAT);
        repeat (8) send(int'($urandom_range(0, 999)), 3, LAT);
        chk("t3_overrun", longint'(overrun), 0);

        load(65536, 65536);
        repeat (8) send(32767, -32768, LAT);
        step();
        chk("t4_sat_hi", obs0[$], 32767);
        chk("t4_sat_lo", obs1[$], -32768);

        run = 1'b0;
        step();
        run = 1'b1;
        step();
        load(3000, -20000);
        send(100, 200, LAT);
        send(300, 400, 3);
        send(500, 600, LAT + 3);
        chk("t5_overrun", longint'(overrun), 1);
        send(700, 800, LAT);
        send(900, 1000, LAT + 1);
        run = 1'b0;
        step();
        chk("t5_clear", longint'(overrun), 0);
        run = 1'b1;
        step();

        n = obs0.size();
        send(1, 2, LAT);
        send(3, 4, 2);
        run = 1'b0;
        step();
        run = 1'b1;
        repeat (LAT) step();
        chk("t6_abort", obs0.size(), n);
        wcoef(0, 4321);
        repeat (4) send(rsamp(), rsamp(), LAT);
        bypass = 1'b1;
        step();
        e0 = cyc + 1;
        send(16'h1234, 16'h1234, 1);
        step();
        chk("t6_bypass", obs0[$], 16'h1234);
        chk("t6_byp_lat", obsc[$] - e0 + 1, 1);
        bypass = 1'b0;
        step();

        for (int r = 0; r < 3; r++) begin
            load(rcoef(), rcoef());
            repeat (60) begin
                if ($urandom_range(0, 29) == 0) begin
                    run = 1'b0;
                    step();
                    run = 1'b1;
                end
                send(rsamp(), rsamp(), int'($urandom_range(1, 10)));
            end
        end

        repeat (LAT + 2) step();
        chk("drain", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
